// File: rtl/vga_draw_engine.sv
// Command-driven framebuffer pixel writer: clear, horizontal/vertical line and filled rectangle.
// Optional VGA_DRAW_PIXCNT_EN adds pix_cnt_o, a count of pixels accepted for the current command.
module vga_draw_engine #(
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int ADDR_BITS  = 11,
  parameter int COLOR_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_mode_i,
  input  logic [ADDR_BITS-1:0]  cmd_x0_i,
  input  logic [ADDR_BITS-1:0]  cmd_y0_i,
  input  logic [ADDR_BITS-1:0]  cmd_x1_i,
  input  logic [ADDR_BITS-1:0]  cmd_y1_i,
  input  logic [COLOR_BITS-1:0] cmd_color_i,
  output logic [ADDR_BITS-1:0]  pix_addr_x_o,
  output logic [ADDR_BITS-1:0]  pix_addr_y_o,
  output logic [COLOR_BITS-1:0] pix_color_o,
  output logic                  pix_we_o,
  input  logic                  pix_ready_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef VGA_DRAW_PIXCNT_EN
  ,
  output logic [2*ADDR_BITS-1:0] pix_cnt_o
`endif
);

  localparam logic [1:0] MODE_CLEAR = 2'd0;
  localparam logic [1:0] MODE_HLINE = 2'd1;
  localparam logic [1:0] MODE_VLINE = 2'd2;

  localparam logic [ADDR_BITS-1:0] X_MAX = ADDR_BITS'(HD - 1);
  localparam logic [ADDR_BITS-1:0] Y_MAX = ADDR_BITS'(VD - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]            mode_q;
  logic [ADDR_BITS-1:0]  x0_q, y0_q, x1_q, y1_q;
  logic [ADDR_BITS-1:0]  xl_q, xh_q, yl_q, yh_q;
  logic [ADDR_BITS-1:0]  xl_c, xh_c, yl_c, yh_c;
  logic [ADDR_BITS-1:0]  x_q, y_q;
  logic [COLOR_BITS-1:0] color_q;
  logic                  accept;
  logic                  last_pix;

  function automatic logic [ADDR_BITS-1:0] clamp(input logic [ADDR_BITS-1:0] v,
                                                 input logic [ADDR_BITS-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [ADDR_BITS-1:0] umin(input logic [ADDR_BITS-1:0] a,
                                                input logic [ADDR_BITS-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [ADDR_BITS-1:0] umax(input logic [ADDR_BITS-1:0] a,
                                                input logic [ADDR_BITS-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign accept   = cmd_valid_i && (state_q == S_IDLE);
  assign last_pix = (x_q == xh_q) && (y_q == yh_q);

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign pix_we_o     = (state_q == S_DRAW);
  assign done_o       = (state_q == S_DONE);
  assign pix_addr_x_o = x_q;
  assign pix_addr_y_o = y_q;
  assign pix_color_o  = color_q;

  // Bound normalisation: clamping after min/max equals min/max of clamped values
  always_comb begin
    xl_c = clamp(umin(x0_q, x1_q), X_MAX);
    xh_c = clamp(umax(x0_q, x1_q), X_MAX);
    yl_c = clamp(umin(y0_q, y1_q), Y_MAX);
    yh_c = clamp(umax(y0_q, y1_q), Y_MAX);
    case (mode_q)
      MODE_CLEAR: begin
        xl_c = '0;
        xh_c = X_MAX;
        yl_c = '0;
        yh_c = Y_MAX;
      end
      MODE_HLINE: begin
        yl_c = clamp(y0_q, Y_MAX);
        yh_c = yl_c;
      end
      MODE_VLINE: begin
        xl_c = clamp(x0_q, X_MAX);
        xh_c = xl_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid_i) state_d = S_SETUP;
      S_SETUP: state_d = S_DRAW;
      S_DRAW:  if (pix_ready_i && last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command capture and bound registers carry no reset; they are always written before use
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mode_q <= cmd_mode_i;
      x0_q   <= cmd_x0_i;
      y0_q   <= cmd_y0_i;
      x1_q   <= cmd_x1_i;
      y1_q   <= cmd_y1_i;
    end
    if (state_q == S_SETUP) begin
      xl_q <= xl_c;
      xh_q <= xh_c;
      yl_q <= yl_c;
      yh_q <= yh_c;
    end
  end

  // Raster walk; the cursor parks on the last pixel so it never passes the bounds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      if (accept) color_q <= cmd_color_i;
      if (state_q == S_SETUP) begin
        x_q <= xl_c;
        y_q <= yl_c;
      end else if ((state_q == S_DRAW) && pix_ready_i && !last_pix) begin
        if (x_q < xh_q) begin
          x_q <= x_q + 1'b1;
        end else begin
          x_q <= xl_q;
          y_q <= y_q + 1'b1;
        end
      end
    end
  end

`ifdef VGA_DRAW_PIXCNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || accept)                        pix_cnt_o <= '0;
    else if ((state_q == S_DRAW) && pix_ready_i) pix_cnt_o <= pix_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vga_draw_engine.sv
// Directed bench for vga_draw_engine: default-size instance for line/rect/reset/back-to-back
// commands and an 8x4 instance for CLEAR under toggling back-pressure.
module tb_vga_draw_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, s_valid;
  logic [1:0]  cmd_mode;
  logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [1:0]  cmd_color;
  logic        b_pready, s_rdy;

  logic        b_ready, b_we, b_busy, b_done;
  logic [10:0] b_x, b_y;
  logic [1:0]  b_color;
  logic        s_ready, s_we, s_busy, s_done;
  logic [10:0] s_x, s_y;
  logic [1:0]  s_color;
`ifdef VGA_DRAW_PIXCNT_EN
  logic [21:0] b_cnt, s_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_draw_engine dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(b_ready), .cmd_mode_i(cmd_mode),
    .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_x1_i(cmd_x1), .cmd_y1_i(cmd_y1),
    .cmd_color_i(cmd_color),
    .pix_addr_x_o(b_x), .pix_addr_y_o(b_y), .pix_color_o(b_color), .pix_we_o(b_we),
    .pix_ready_i(b_pready), .busy_o(b_busy), .done_o(b_done)
`ifdef VGA_DRAW_PIXCNT_EN
    , .pix_cnt_o(b_cnt)
`endif
  );

  vga_draw_engine #(.HD(8), .VD(4), .ADDR_BITS(11), .COLOR_BITS(2)) dut_s (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(s_valid), .cmd_ready_o(s_ready), .cmd_mode_i(cmd_mode),
    .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_x1_i(cmd_x1), .cmd_y1_i(cmd_y1),
    .cmd_color_i(cmd_color),
    .pix_addr_x_o(s_x), .pix_addr_y_o(s_y), .pix_color_o(s_color), .pix_we_o(s_we),
    .pix_ready_i(s_rdy), .busy_o(s_busy), .done_o(s_done)
`ifdef VGA_DRAW_PIXCNT_EN
    , .pix_cnt_o(s_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the default instance from an IDLE cycle and walk its expected raster
  task automatic do_cmd(input string tag, input logic [1:0] m,
                        input int ax0, input int ay0, input int ax1, input int ay1,
                        input logic [1:0] col,
                        input int xl, input int xh, input int yl, input int yh,
                        input bit hold);
    cmd_mode  = m;
    cmd_x0    = 11'(ax0);
    cmd_y0    = 11'(ay0);
    cmd_x1    = 11'(ax1);
    cmd_y1    = 11'(ay1);
    cmd_color = col;
    cmd_valid = 1'b1;
    chk({tag, "_acc_rdy"}, b_ready, 1);
    tick();
    cmd_valid = hold;
    chk({tag, "_setup_busy"}, b_busy, 1);
    chk({tag, "_setup_we"}, b_we, 0);
    chk({tag, "_setup_rdy"}, b_ready, 0);
    tick();
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        chk({tag, "_we"}, b_we, 1);
        chk({tag, "_x"}, b_x, x);
        chk({tag, "_y"}, b_y, y);
        chk({tag, "_rdy_busy"}, b_ready, 0);
        tick();
      end
    end
    chk({tag, "_done"}, b_done, 1);
    chk({tag, "_done_we"}, b_we, 0);
    chk({tag, "_color"}, b_color, col);
    chk({tag, "_done_rdy"}, b_ready, 0);
    tick();
    chk({tag, "_done_off"}, b_done, 0);
    chk({tag, "_idle_rdy"}, b_ready, 1);
    chk({tag, "_idle_busy"}, b_busy, 0);
  endtask

  initial begin
    int k;
    int cyc;
    rst = 1'b1;
    cmd_valid = 1'b0;
    s_valid = 1'b0;
    cmd_mode = 2'd0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_color = 2'd0;
    b_pready = 1'b1;
    s_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_x", b_x, 0);
    chk("rst_y", b_y, 0);
    chk("rst_color", b_color, 0);
    chk("rst_we", b_we, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_ready", b_ready, 1);
    tick();

    do_cmd("rect", 2'd3, 2, 3, 4, 4, 2'd2, 2, 4, 3, 4, 1'b0);
`ifdef VGA_DRAW_PIXCNT_EN
    chk("rect_cnt", b_cnt, 6);
`endif
    do_cmd("hline", 2'd1, 9, 7, 5, 300, 2'd1, 5, 9, 7, 7, 1'b0);
    do_cmd("vline", 2'd2, 2000, 1020, 0, 1100, 2'd3, 1279, 1279, 1020, 1023, 1'b0);
    do_cmd("single", 2'd3, 100, 50, 100, 50, 2'd1, 100, 100, 50, 50, 1'b0);

    // Reset lands while the third pixel of a rectangle is on the port
    cmd_mode = 2'd3;
    cmd_x0 = 11'd10; cmd_y0 = 11'd10; cmd_x1 = 11'd13; cmd_y1 = 11'd11;
    cmd_color = 2'd2;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("mid_x", b_x, 12);
    chk("mid_y", b_y, 10);
    chk("mid_we", b_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_we", b_we, 0);
    chk("mrst_ready", b_ready, 1);
    chk("mrst_busy", b_busy, 0);
    chk("mrst_done", b_done, 0);
    repeat (3) begin
      tick();
      chk("mrst_no_done", b_done, 0);
      chk("mrst_idle", b_ready, 1);
    end
    do_cmd("after_rst", 2'd3, 1, 0, 0, 1, 2'd3, 0, 1, 0, 1, 1'b0);

    // Valid held across two commands
    do_cmd("b2b_a", 2'd1, 3, 4, 5, 0, 2'd1, 3, 5, 4, 4, 1'b1);
    do_cmd("b2b_b", 2'd2, 6, 2, 0, 4, 2'd2, 6, 6, 2, 4, 1'b0);

    // CLEAR on the 8x4 instance with alternating back-pressure
    cmd_mode = 2'd0;
    cmd_x0 = 11'd5; cmd_y0 = 11'd5; cmd_x1 = 11'd1; cmd_y1 = 11'd1;
    cmd_color = 2'd3;
    s_valid = 1'b1;
    chk("clr_acc_rdy", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("clr_setup_we", s_we, 0);
    tick();
    s_rdy = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 200) begin
      chk("clr_we", s_we, 1);
      chk("clr_x", s_x, k % 8);
      chk("clr_y", s_y, k / 8);
      chk("clr_color", s_color, 3);
      if (s_rdy) k++;
      tick();
      s_rdy = ~s_rdy;
      cyc++;
    end
    chk("clr_count", k, 32);
    chk("clr_done", s_done, 1);
    chk("clr_done_we", s_we, 0);
`ifdef VGA_DRAW_PIXCNT_EN
    chk("clr_cnt", s_cnt, 32);
`endif
    tick();
    chk("clr_idle", s_ready, 1);
    chk("clr_done_off", s_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
